ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_fetch_buf.sv | 77 +++++++
 rtl/ifu_fetch.sv | 147 ++++++++++++++
 tb/tb_ifu_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ==== ifu_pkg -- shared types and defaults for the instruction fetch unit (rev 1.0) ====
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0001_0100;
  localparam int          IFU_FB_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] pc;
    logic        start_hi;
  } fb_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_buf.sv
`default_nettype none
// ==== ifu_fetch_buf -- 64-bit fetch FIFO with per-entry low/high word sequencing (rev 1.0) ====
module ifu_fetch_buf
  import ifu_pkg::*;
#(
  parameter int DEPTH = IFU_FB_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        push,
  input  fb_entry_t   push_entry,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        pop,
  output logic        full,
  output logic        afull
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  fb_entry_t        mem [DEPTH];
  fb_entry_t        head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             lo_done;
  logic             half;
  logic             xfer;

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);
  // Entries fetched from an odd-word redirect target begin on their high word.
  assign half  = head.start_hi | lo_done;
  assign xfer  = valid & ready;
  assign pop   = xfer & half;
  assign full  = (count == CNT_FULL);
  assign afull = (count == (CNT_FULL - CNT_ONE));

  assign inst = valid ? (half ? head.data[63:32] : head.data[31:0]) : 32'd0;
  assign pc   = valid ? (head.pc + {29'd0, half, 2'b00}) : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      lo_done <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      lo_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (xfer) lo_done <= ~half;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ==== ifu_fetch -- fetch FSM and PC sequencing into a 64-bit fetch buffer (rev 1.0) ====
// Optional macro IFU_FETCH_PERF_EN adds saturating request/drop performance counters.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          FB_DEPTH = IFU_FB_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exu_ifu_redirect_valid,
  input  logic [31:0] exu_ifu_redirect_pc,
  output logic        ifu_icu_req_ic1,
  output logic [28:0] ifu_icu_addr_ic1,
  input  logic        icu_ifu_ack_ic1,
  input  logic        icu_ifu_data_valid_ic2,
  input  logic [63:0] icu_ifu_data_ic2,
  output logic        ifu_de_valid,
  output logic [31:0] ifu_de_inst,
  output logic [31:0] ifu_de_pc,
`ifdef IFU_FETCH_PERF_EN
  output logic [31:0] ifu_perf_req_cnt,
  output logic [31:0] ifu_perf_drop_cnt,
`endif
  input  logic        de_ifu_ready
);

  ifu_state_e  state;
  ifu_state_e  state_nxt;
  logic [31:2] fetch_pc;
  logic [31:2] fetch_pc_nxt;
  logic [31:2] blk_pc;
  logic [31:2] redir_pc;
  logic        redirect;
  logic        dv;
  logic        req_fire;
  logic        push;
  logic        fb_full;
  logic        fb_afull;
  logic        fb_pop;
  fb_entry_t   push_entry;
  logic        unused_redir_lo;

  assign redirect        = exu_ifu_redirect_valid;
  assign redir_pc        = exu_ifu_redirect_pc[31:2];
  assign unused_redir_lo = ^exu_ifu_redirect_pc[1:0];
  assign dv              = icu_ifu_data_valid_ic2;
  assign req_fire        = (state == ST_REQ) && icu_ifu_ack_ic1;

  assign ifu_icu_req_ic1  = (state == ST_REQ);
  assign ifu_icu_addr_ic1 = ifu_icu_req_ic1 ? fetch_pc[31:3] : 29'd0;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = redir_pc;
          state_nxt    = ST_REQ;
        end else if (!fb_full) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_nxt = redir_pc;
          // An ack in the redirect cycle leaves stale data in flight.
          if (icu_ifu_ack_ic1) state_nxt = ST_DROP;
        end else if (icu_ifu_ack_ic1) begin
          fetch_pc_nxt = {fetch_pc[31:3] + 29'd1, 1'b0};
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_nxt = redir_pc;
          state_nxt    = dv ? ST_REQ : ST_DROP;
        end else if (dv) begin
          push      = 1'b1;
          state_nxt = (fb_afull && !fb_pop) ? ST_IDLE : ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect) fetch_pc_nxt = redir_pc;
        if (dv)       state_nxt    = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC[31:2];
      blk_pc   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (req_fire && !redirect) blk_pc <= fetch_pc;
    end
  end

  assign push_entry.data     = icu_ifu_data_ic2;
  assign push_entry.pc       = {blk_pc[31:3], 3'b000};
  assign push_entry.start_hi = blk_pc[2];

  ifu_fetch_buf #(
    .DEPTH (FB_DEPTH)
  ) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .ready      (de_ifu_ready),
    .valid      (ifu_de_valid),
    .inst       (ifu_de_inst),
    .pc         (ifu_de_pc),
    .pop        (fb_pop),
    .full       (fb_full),
    .afull      (fb_afull)
  );

`ifdef IFU_FETCH_PERF_EN
  logic drop_evt;
  assign drop_evt = dv && ((state == ST_DROP) || ((state == ST_WAIT) && redirect));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifu_perf_req_cnt  <= '0;
      ifu_perf_drop_cnt <= '0;
    end else begin
      if (req_fire && (ifu_perf_req_cnt != 32'hFFFF_FFFF))
        ifu_perf_req_cnt <= ifu_perf_req_cnt + 32'd1;
      if (drop_evt && (ifu_perf_drop_cnt != 32'hFFFF_FFFF))
        ifu_perf_drop_cnt <= ifu_perf_drop_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// tb_ifu_fetch -- randomized icache/decode environment with a stream-level PC reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0001_0100;
  localparam int          FB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        exu_ifu_redirect_valid = 1'b0;
  logic [31:0] exu_ifu_redirect_pc = '0;
  logic        ifu_icu_req_ic1;
  logic [28:0] ifu_icu_addr_ic1;
  logic        icu_ifu_ack_ic1 = 1'b0;
  logic        icu_ifu_data_valid_ic2 = 1'b0;
  logic [63:0] icu_ifu_data_ic2 = '0;
  logic        ifu_de_valid;
  logic [31:0] ifu_de_inst;
  logic [31:0] ifu_de_pc;
  logic        de_ifu_ready = 1'b0;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] ifu_perf_req_cnt;
  logic [31:0] ifu_perf_drop_cnt;
`endif

  ifu_fetch #(
    .RESET_PC (RESET_PC),
    .FB_DEPTH (FB_DEPTH)
  ) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .exu_ifu_redirect_valid (exu_ifu_redirect_valid),
    .exu_ifu_redirect_pc    (exu_ifu_redirect_pc),
    .ifu_icu_req_ic1        (ifu_icu_req_ic1),
    .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
    .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
    .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
    .icu_ifu_data_ic2       (icu_ifu_data_ic2),
    .ifu_de_valid           (ifu_de_valid),
    .ifu_de_inst            (ifu_de_inst),
    .ifu_de_pc              (ifu_de_pc),
`ifdef IFU_FETCH_PERF_EN
    .ifu_perf_req_cnt       (ifu_perf_req_cnt),
    .ifu_perf_drop_cnt      (ifu_perf_drop_cnt),
`endif
    .de_ifu_ready           (de_ifu_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // environment knobs
  int lat_min, lat_max, ack_dly_max, rdy_prob;

  // icache model state
  bit          pend;
  int          lat;
  int          ack_dly;
  logic [31:0] pa;
  logic [28:0] ack_addrs[$];

  // decode-side reference: expected next PC of the instruction stream
  logic [31:0] exp_pc;
  logic [31:0] xfer_pcs[$];
  logic [31:0] xfer_insts[$];
  int          xfers;

  bit          redir_v;
  logic [31:0] redir_pc;
  bit          prev_redir, prev_hold, prev_wait;
  logic [31:0] prev_inst, prev_pc;
  logic [28:0] prev_addr;
  logic        last_req;
  logic [28:0] last_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction memory image: two fixed words at the reset vector, a hash elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0001_0100) return 32'hbbbb_bbbb;
    if (a == 32'h0001_0104) return 32'haaaa_aaaa;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    resetn = 1'b0;
    exu_ifu_redirect_valid = 1'b0;
    exu_ifu_redirect_pc    = '0;
    icu_ifu_ack_ic1        = 1'b0;
    icu_ifu_data_valid_ic2 = 1'b0;
    icu_ifu_data_ic2       = '0;
    de_ifu_ready           = 1'b0;
    pend = 0; ack_dly = 0; redir_v = 0;
    prev_redir = 0; prev_hold = 0; prev_wait = 0;
    exp_pc = RESET_PC;
    ack_addrs.delete(); xfer_pcs.delete(); xfer_insts.delete();
    #1;
    check("rst_req",   ifu_icu_req_ic1,  0);
    check("rst_addr",  ifu_icu_addr_ic1, 0);
    check("rst_valid", ifu_de_valid,     0);
    check("rst_inst",  ifu_de_inst,      0);
    check("rst_pc",    ifu_de_pc,        0);
`ifdef IFU_FETCH_PERF_EN
    check("rst_perf_req",  ifu_perf_req_cnt,  0);
    check("rst_perf_drop", ifu_perf_drop_cnt, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // One clock of environment: icache, decode, redirect and stream checks at the falling edge.
  task automatic step();
    @(negedge clk);
    if (prev_redir) begin
      check("flush_valid", ifu_de_valid, 0);
    end else if (prev_hold) begin
      check("hold_pc",   {ifu_de_valid, ifu_de_pc}, {1'b1, prev_pc});
      check("hold_inst", ifu_de_inst, prev_inst);
    end
    if (prev_wait && !prev_redir)
      check("addr_stable", {ifu_icu_req_ic1, ifu_icu_addr_ic1}, {1'b1, prev_addr});
    check("one_outstanding", ifu_icu_req_ic1 & pend, 0);

    icu_ifu_data_valid_ic2 = 1'b0;
    if (pend) begin
      if (lat == 0) begin
        icu_ifu_data_valid_ic2 = 1'b1;
        icu_ifu_data_ic2       = {word_at(pa + 32'd4), word_at(pa)};
        pend = 0;
      end else begin
        lat--;
      end
    end

    icu_ifu_ack_ic1 = 1'b0;
    last_req  = ifu_icu_req_ic1;
    last_addr = ifu_icu_addr_ic1;
    if (ifu_icu_req_ic1) begin
      if (ack_dly == 0) begin
        icu_ifu_ack_ic1 = 1'b1;
        pend = 1;
        pa   = {ifu_icu_addr_ic1, 3'b000};
        lat  = int'($urandom_range(lat_max, lat_min));
        ack_addrs.push_back(ifu_icu_addr_ic1);
        ack_dly = (ack_dly_max == 0) ? 0 : int'($urandom_range(ack_dly_max, 0));
      end else begin
        ack_dly--;
      end
    end

    de_ifu_ready = ($urandom_range(99, 0) < rdy_prob);
    exu_ifu_redirect_valid = redir_v;
    exu_ifu_redirect_pc    = redir_pc;
    if (ifu_de_valid && de_ifu_ready) begin
      check("de_pc",   ifu_de_pc,   exp_pc);
      check("de_inst", ifu_de_inst, word_at(exp_pc));
      xfer_pcs.push_back(ifu_de_pc);
      xfer_insts.push_back(ifu_de_inst);
      xfers++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redir_v) exp_pc = {redir_pc[31:2], 2'b00};

    prev_redir = redir_v;
    prev_hold  = ifu_de_valid && !de_ifu_ready;
    prev_inst  = ifu_de_inst;
    prev_pc    = ifu_de_pc;
    prev_wait  = ifu_icu_req_ic1 && !icu_ifu_ack_ic1;
    prev_addr  = ifu_icu_addr_ic1;
    redir_v    = 0;
  endtask

  initial begin
    int x0;
    int guard;
    xfers = 0; redir_pc = '0;

    // reset release and an icache hit at the reset vector
    lat_min = 0; lat_max = 0; ack_dly_max = 0; rdy_prob = 100;
    reset_dut();
    step();
    check("first_req",  last_req,  1);
    check("first_addr", last_addr, 29'h2020);
    repeat (8) step();
    check("hit_xfer_cnt", xfer_pcs.size() >= 2, 1);
    if (xfer_pcs.size() >= 2) begin
      check("hit_pc0",   xfer_pcs[0],   32'h0001_0100);
      check("hit_inst0", xfer_insts[0], 32'hbbbb_bbbb);
      check("hit_pc1",   xfer_pcs[1],   32'h0001_0104);
      check("hit_inst1", xfer_insts[1], 32'haaaa_aaaa);
    end

    // decode never ready: buffer fills and fetch stops
    rdy_prob = 0;
    reset_dut();
    repeat (40) step();
    check("full_acks",  ack_addrs.size(), FB_DEPTH);
    check("full_req",   last_req, 0);
    check("full_head",  {ifu_de_valid, ifu_de_pc}, {1'b1, RESET_PC});

    // redirect while waiting for a slow return
    rdy_prob = 100; lat_min = 6; lat_max = 6;
    reset_dut();
    step();
    redir_v = 1; redir_pc = 32'h0000_2004;
    ack_addrs.delete(); xfer_pcs.delete(); xfer_insts.delete();
    step();
    repeat (40) step();
    check("drop_ack_cnt", ack_addrs.size() >= 1, 1);
    if (ack_addrs.size() >= 1) check("drop_next_addr", ack_addrs[0], 29'h400);
    check("drop_xfer_cnt", xfer_pcs.size() >= 2, 1);
    if (xfer_pcs.size() >= 2) begin
      check("drop_first_pc",  xfer_pcs[0], 32'h0000_2004);
      check("drop_second_pc", xfer_pcs[1], 32'h0000_2008);
    end
`ifdef IFU_FETCH_PERF_EN
    check("perf_drop", ifu_perf_drop_cnt, 1);
`endif

    // late ack with a redirect in the second request cycle
    lat_min = 0; lat_max = 0;
    reset_dut();
    ack_dly = 5;
    step(); step();
    redir_v = 1; redir_pc = 32'h0000_3000;
    step();
    check("late_addr_old", {last_req, last_addr}, {1'b1, 29'h2020});
    step();
    check("late_addr_new", {last_req, last_addr}, {1'b1, 29'h600});
    step(); step();
    check("late_ack_cnt", ack_addrs.size(), 1);
    if (ack_addrs.size() == 1) check("late_ack_addr", ack_addrs[0], 29'h600);
    step();
`ifdef IFU_FETCH_PERF_EN
    check("perf_req", ifu_perf_req_cnt, 1);
`endif
    repeat (10) step();

    // PC wrap at the top of the address space
    lat_min = 0; lat_max = 2;
    reset_dut();
    repeat (5) step();
    redir_v = 1; redir_pc = 32'hFFFF_FFF8;
    step();
    ack_addrs.delete(); xfer_pcs.delete(); xfer_insts.delete();
    repeat (25) step();
    check("wrap_ack_cnt", ack_addrs.size() >= 2, 1);
    if (ack_addrs.size() >= 2) begin
      check("wrap_addr0", ack_addrs[0], 29'h1FFF_FFFF);
      check("wrap_addr1", ack_addrs[1], 29'h0);
    end
    check("wrap_xfer_cnt", xfer_pcs.size() >= 3, 1);
    if (xfer_pcs.size() >= 3) check("wrap_pc2", xfer_pcs[2], 32'h0000_0000);

    // random latencies, ready and redirects against the stream model
    lat_min = 0; lat_max = 5; ack_dly_max = 3; rdy_prob = 60;
    reset_dut();
    x0 = xfers;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        guard = 0;
        while (!pend && guard < 50) begin
          step();
          guard++;
        end
        check("midrst_pending", pend, 1);
        reset_dut();
        step();
        check("midrst_req", {last_req, last_addr}, {1'b1, 29'h2020});
      end
      if ($urandom_range(99, 0) < 3) begin
        redir_v  = 1;
        redir_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                               : $urandom();
      end
      step();
    end
    check("rand_progress", (xfers - x0) > 200, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
